// File: rtl/branch_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// branch_ctrl_pkg : funct3 codes, FSM states and taken-decode helpers
// Revision: 1.0
// ============================================================================
package branch_ctrl_pkg;

  localparam logic [2:0] FNC_BEQ  = 3'b000;
  localparam logic [2:0] FNC_BNE  = 3'b001;
  localparam logic [2:0] FNC_BLT  = 3'b100;
  localparam logic [2:0] FNC_BGE  = 3'b101;
  localparam logic [2:0] FNC_BLTU = 3'b110;
  localparam logic [2:0] FNC_BGEU = 3'b111;

  typedef enum logic [0:0] {
    BC_RUN   = 1'b0,
    BC_FLUSH = 1'b1
  } bc_state_e;

  // 010/011 are not conditional branches
  function automatic logic f3_is_branch(input logic [2:0] f3);
    return f3[2] | ~f3[1];
  endfunction

  function automatic logic br_taken(input logic [2:0] f3, input logic eq, input logic lt);
    logic t;
    case (f3)
      FNC_BEQ:            t = eq;
      FNC_BNE:            t = ~eq;
      FNC_BLT, FNC_BLTU:  t = lt;
      FNC_BGE, FNC_BGEU:  t = ~lt;
      default:            t = 1'b0;
    endcase
    return t;
  endfunction

endpackage
`default_nettype wire

// File: rtl/branch_bht.sv
`default_nettype none
// ============================================================================
// branch_bht : table of 2-bit saturating counters, read-before-write
// Revision: 1.0
// ============================================================================
module branch_bht #(
  parameter int IDX_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_taken,
  input  logic             upd_en,
  input  logic [IDX_W-1:0] upd_idx,
  input  logic             upd_taken
);

  localparam int ENTRIES = 1 << IDX_W;

  logic [1:0] tbl_q [ENTRIES];
  logic [1:0] tbl_d [ENTRIES];

  always_comb begin
    tbl_d = tbl_q;
    if (upd_en) begin
      if (upd_taken && (tbl_q[upd_idx] != 2'b11)) begin
        tbl_d[upd_idx] = tbl_q[upd_idx] + 2'd1;
      end else if (!upd_taken && (tbl_q[upd_idx] != 2'b00)) begin
        tbl_d[upd_idx] = tbl_q[upd_idx] - 2'd1;
      end
    end
  end

  // Read sees the registered value, so a same-index update is not bypassed
  assign rd_taken = tbl_q[rd_idx][1];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        tbl_q[i] <= 2'b01;
      end
    end else begin
      tbl_q <= tbl_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/branch_ctrl.sv
`default_nettype none
// ============================================================================
// branch_ctrl : EX-stage branch resolve, redirect/flush sequencing, counters.
// Optional predictor table compiled in with macro BRANCH_PRED_EN.
// Revision: 1.0
// ============================================================================
module branch_ctrl
  import branch_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int BHT_IDX_W    = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic        ex_is_branch,
  input  logic        ex_is_jump,
  input  logic [2:0]  ex_funct3,
  input  logic [31:0] ex_pc,
  input  logic        ex_pred_taken,
  output logic        brun,
  input  logic        breq,
  input  logic        brlt,
  output logic        redirect,
  output logic        redirect_taken,
  output logic        flush,
  input  logic [31:0] if_pc,
  output logic        if_pred_taken,
  input  logic        cnt_clr,
  output logic [31:0] br_cnt,
  output logic [31:0] mispred_cnt
);

  bc_state_e   state_q, state_d;
  logic [3:0]  fl_cnt_q, fl_cnt_d;
  logic [31:0] br_cnt_q, br_cnt_d;
  logic [31:0] mispred_cnt_q, mispred_cnt_d;
  logic        taken, pred, bht_pred;
  logic        in_run, resolve, mispred, jump;

  assign brun  = ex_funct3[1];
  assign taken = br_taken(ex_funct3, breq, brlt);

`ifdef BRANCH_PRED_EN
  assign pred = ex_pred_taken;

  branch_bht #(
    .IDX_W (BHT_IDX_W)
  ) u_bht (
    .clk       (clk),
    .rst       (rst),
    .rd_idx    (if_pc[BHT_IDX_W+1:2]),
    .rd_taken  (bht_pred),
    .upd_en    (resolve),
    .upd_idx   (ex_pc[BHT_IDX_W+1:2]),
    .upd_taken (taken)
  );
`else
  // Static not-taken: every taken branch is a mispredict
  assign pred     = 1'b0;
  assign bht_pred = 1'b0;
`endif

  logic unused_bits;
  assign unused_bits = ^{ex_pc, if_pc, ex_pred_taken, (BHT_IDX_W > 0)};

  always_comb begin
    in_run         = (state_q == BC_RUN);
    resolve        = in_run && ex_valid && ex_is_branch && f3_is_branch(ex_funct3);
    mispred        = resolve && (taken != pred);
    jump           = in_run && ex_valid && ex_is_jump;
    redirect       = !rst && (mispred || jump);
    redirect_taken = jump || taken;
    flush          = !rst && (!in_run || mispred || jump);
    if_pred_taken  = !rst && bht_pred;

    state_d  = state_q;
    fl_cnt_d = fl_cnt_q;
    case (state_q)
      BC_RUN: begin
        if ((mispred || jump) && (FLUSH_CYCLES > 1)) begin
          state_d  = BC_FLUSH;
          fl_cnt_d = 4'(FLUSH_CYCLES - 1);
        end
      end
      BC_FLUSH: begin
        fl_cnt_d = fl_cnt_q - 4'd1;
        if (fl_cnt_q <= 4'd1) begin
          state_d = BC_RUN;
        end
      end
      default: state_d = BC_RUN;
    endcase

    // Clear wins over a same-cycle increment
    if (cnt_clr) begin
      br_cnt_d      = '0;
      mispred_cnt_d = '0;
    end else begin
      br_cnt_d      = br_cnt_q + {31'd0, resolve};
      mispred_cnt_d = mispred_cnt_q + {31'd0, mispred};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= BC_RUN;
      fl_cnt_q      <= '0;
      br_cnt_q      <= '0;
      mispred_cnt_q <= '0;
    end else begin
      state_q       <= state_d;
      fl_cnt_q      <= fl_cnt_d;
      br_cnt_q      <= br_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  assign br_cnt      = br_cnt_q;
  assign mispred_cnt = mispred_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_branch_ctrl.sv
`default_nettype none
// ============================================================================
// tb_branch_ctrl : vector table, directed corner sequences and random run
// against a behavioural model. Revision: 1.0
// ============================================================================
module tb_branch_ctrl;

`ifdef BRANCH_PRED_EN
  localparam bit PRED_EN = 1'b1;
`else
  localparam bit PRED_EN = 1'b0;
`endif
  localparam int FC = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ex_valid = 1'b0, ex_is_branch = 1'b0, ex_is_jump = 1'b0;
  logic [2:0]  ex_funct3 = 3'd0;
  logic [31:0] ex_pc = 32'd0, if_pc = 32'd0;
  logic        ex_pred_taken = 1'b0, breq = 1'b0, brlt = 1'b0, cnt_clr = 1'b0;

  logic        brun, redirect, redirect_taken, flush, if_pred_taken;
  logic [31:0] br_cnt, mispred_cnt;
  logic        brun4, redirect4, redirect_taken4, flush4, if_pred_taken4;
  logic [31:0] br_cnt4, mispred_cnt4;

  branch_ctrl dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_is_branch(ex_is_branch),
    .ex_is_jump(ex_is_jump), .ex_funct3(ex_funct3), .ex_pc(ex_pc),
    .ex_pred_taken(ex_pred_taken), .brun(brun), .breq(breq), .brlt(brlt),
    .redirect(redirect), .redirect_taken(redirect_taken), .flush(flush),
    .if_pc(if_pc), .if_pred_taken(if_pred_taken), .cnt_clr(cnt_clr),
    .br_cnt(br_cnt), .mispred_cnt(mispred_cnt)
  );

  branch_ctrl #(.FLUSH_CYCLES(4)) dut4 (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_is_branch(ex_is_branch),
    .ex_is_jump(ex_is_jump), .ex_funct3(ex_funct3), .ex_pc(ex_pc),
    .ex_pred_taken(ex_pred_taken), .brun(brun4), .breq(breq), .brlt(brlt),
    .redirect(redirect4), .redirect_taken(redirect_taken4), .flush(flush4),
    .if_pc(if_pc), .if_pred_taken(if_pred_taken4), .cnt_clr(cnt_clr),
    .br_cnt(br_cnt4), .mispred_cnt(mispred_cnt4)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          failures = 0;
  int          m_fl = 0;
  int unsigned m_br = 0, m_mis = 0;
  int          m_bht [64];

  typedef struct {
    logic       v, br, jp;
    logic [2:0] f3;
    logic       eq, lt;
    logic       e_brun, e_red, e_rt, e_cnt;
  } vec_t;
  vec_t vecs [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit m_taken(input logic [2:0] f3, input logic eq, input logic lt);
    case (f3)
      3'd0: return eq;
      3'd1: return !eq;
      3'd4, 3'd6: return lt;
      3'd5, 3'd7: return !lt;
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit m_legal(input logic [2:0] f3);
    return !(f3 == 3'd2 || f3 == 3'd3);
  endfunction

  task automatic drv(input logic v, input logic br, input logic jp, input logic [2:0] f3,
                     input logic eq, input logic lt, input logic pr, input logic [31:0] pc);
    @(negedge clk);
    ex_valid = v; ex_is_branch = br; ex_is_jump = jp; ex_funct3 = f3;
    breq = eq; brlt = lt; ex_pred_taken = pr; ex_pc = pc;
    cnt_clr = 1'b0; rst = 1'b0;
  endtask

  task automatic idle();
    drv(1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 32'd0);
  endtask

  // Compare outputs of the main DUT against the model, then advance the model
  task automatic step();
    bit busy, tk, pr, res, mis, jmp, e_red, e_fl, e_ifp;
    int idx;
    #1;
    busy  = (m_fl > 0);
    tk    = m_taken(ex_funct3, breq, brlt);
    pr    = PRED_EN ? ex_pred_taken : 1'b0;
    res   = !busy && ex_valid && ex_is_branch && m_legal(ex_funct3);
    mis   = res && (tk != pr);
    jmp   = !busy && ex_valid && ex_is_jump;
    e_red = !rst && (mis || jmp);
    e_fl  = !rst && (busy || mis || jmp);
    e_ifp = !rst && PRED_EN && (m_bht[(if_pc >> 2) % 64] >= 2);
    chk("brun", brun, ex_funct3[1]);
    chk("redirect", redirect, e_red);
    if (e_red) chk("redirect_taken", redirect_taken, jmp ? 1 : tk);
    chk("flush", flush, e_fl);
    chk("if_pred_taken", if_pred_taken, e_ifp);
    if (!rst) begin
      chk("br_cnt", br_cnt, m_br);
      chk("mispred_cnt", mispred_cnt, m_mis);
    end
    @(posedge clk);
    if (rst) begin
      m_fl = 0; m_br = 0; m_mis = 0;
      foreach (m_bht[i]) m_bht[i] = 1;
    end else begin
      if (mis || jmp) m_fl = FC - 1;
      else if (busy) m_fl--;
      if (cnt_clr) begin
        m_br = 0; m_mis = 0;
      end else begin
        m_br += res; m_mis += mis;
      end
      idx = (ex_pc >> 2) % 64;
      if (PRED_EN && res) begin
        if (tk && m_bht[idx] < 3) m_bht[idx]++;
        else if (!tk && m_bht[idx] > 0) m_bht[idx]--;
      end
    end
  endtask

  task automatic do_reset();
    idle(); rst = 1'b1; step();
    idle(); rst = 1'b1; step();
  endtask

  initial begin
    int unsigned b0;
    foreach (m_bht[i]) m_bht[i] = 1;
    //           v    br   jp   f3      eq   lt   brun red  rt   cnt
    vecs[0]  = '{1'b1,1'b1,1'b0,3'b000,1'b1,1'b0,1'b0,1'b1,1'b1,1'b1};
    vecs[1]  = '{1'b1,1'b1,1'b0,3'b000,1'b0,1'b1,1'b0,1'b0,1'b0,1'b1};
    vecs[2]  = '{1'b1,1'b1,1'b0,3'b001,1'b0,1'b0,1'b0,1'b1,1'b1,1'b1};
    vecs[3]  = '{1'b1,1'b1,1'b0,3'b001,1'b1,1'b1,1'b0,1'b0,1'b0,1'b1};
    vecs[4]  = '{1'b1,1'b1,1'b0,3'b100,1'b0,1'b1,1'b0,1'b1,1'b1,1'b1};
    vecs[5]  = '{1'b1,1'b1,1'b0,3'b101,1'b0,1'b1,1'b0,1'b0,1'b0,1'b1};
    vecs[6]  = '{1'b1,1'b1,1'b0,3'b110,1'b0,1'b0,1'b1,1'b0,1'b0,1'b1};
    vecs[7]  = '{1'b1,1'b1,1'b0,3'b111,1'b0,1'b0,1'b1,1'b1,1'b1,1'b1};
    vecs[8]  = '{1'b1,1'b1,1'b0,3'b010,1'b1,1'b1,1'b1,1'b0,1'b0,1'b0};
    vecs[9]  = '{1'b1,1'b1,1'b0,3'b011,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0};
    vecs[10] = '{1'b1,1'b0,1'b1,3'b010,1'b0,1'b0,1'b1,1'b1,1'b1,1'b0};
    vecs[11] = '{1'b0,1'b1,1'b0,3'b000,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0};

    do_reset();
    idle();
    #1;
    chk("reset_flush", flush, 0);
    chk("reset_redirect", redirect, 0);
    chk("reset_br_cnt", br_cnt, 0);
    chk("reset_mispred_cnt", mispred_cnt, 0);
    chk("reset_if_pred", if_pred_taken, 0);
    step();

    // BEQ taken, predicted not taken: two-cycle flush, both counters at 1
    drv(1'b1, 1'b1, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0, 32'h100);
    #1;
    chk("beq_redirect", redirect, 1);
    chk("beq_redirect_taken", redirect_taken, 1);
    chk("beq_flush0", flush, 1);
    step();
    idle(); #1; chk("beq_flush1", flush, 1); step();
    idle(); #1;
    chk("beq_flush_end", flush, 0);
    chk("beq_br_cnt", br_cnt, 1);
    chk("beq_mispred_cnt", mispred_cnt, 1);
    step();

    for (int i = 0; i < 12; i++) begin
      b0 = m_br;
      drv(vecs[i].v, vecs[i].br, vecs[i].jp, vecs[i].f3, vecs[i].eq, vecs[i].lt, 1'b0, 32'h200);
      #1;
      chk($sformatf("vec%0d_brun", i), brun, vecs[i].e_brun);
      chk($sformatf("vec%0d_redirect", i), redirect, vecs[i].e_red);
      if (vecs[i].e_red) chk($sformatf("vec%0d_rtaken", i), redirect_taken, vecs[i].e_rt);
      step();
      idle(); #1; chk($sformatf("vec%0d_br_cnt", i), br_cnt, b0 + vecs[i].e_cnt); step();
      idle(); step();
      idle(); step();
    end

    // JAL followed immediately by a taken branch: only the jump redirects
    b0 = m_br;
    drv(1'b1, 1'b0, 1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 32'h300);
    #1; chk("jal_redirect", redirect, 1); chk("jal_rtaken", redirect_taken, 1);
    step();
    drv(1'b1, 1'b1, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0, 32'h304);
    #1; chk("jal_next_masked", redirect, 0); chk("jal_next_flush", flush, 1);
    step();
    idle(); #1; chk("jal_br_cnt", br_cnt, b0); step();

    // Four-cycle flush on the FLUSH_CYCLES=4 instance
    do_reset();
    drv(1'b1, 1'b0, 1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 32'h400);
    #1; chk("fc4_flush0", flush4, 1); step();
    for (int k = 1; k < 4; k++) begin
      idle(); #1; chk($sformatf("fc4_flush%0d", k), flush4, 1); step();
    end
    idle(); #1; chk("fc4_flush_end", flush4, 0); step();

    // Reset during the first FLUSH cycle aborts the flush
    drv(1'b1, 1'b1, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0, 32'h500);
    step();
    idle(); #1; chk("rstmid_pre", flush4, 1);
    rst = 1'b1; #1; chk("rstmid_during", flush4, 0);
    step();
    idle(); #1;
    chk("rstmid_flush", flush4, 0);
    chk("rstmid_br_cnt", br_cnt4, 0);
    chk("rstmid_mis_cnt", mispred_cnt4, 0);
    step();
    drv(1'b1, 1'b1, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0, 32'h504);
    #1; chk("rstmid_run_redirect", redirect4, 1); step();
    for (int k = 0; k < 4; k++) begin idle(); step(); end

    // Clear together with a resolve leaves both counters at zero
    drv(1'b1, 1'b1, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0, 32'h600);
    cnt_clr = 1'b1;
    step();
    idle(); #1; chk("clr_br_cnt", br_cnt, 0); chk("clr_mis_cnt", mispred_cnt, 0); step();
    idle(); step();

`ifdef BRANCH_PRED_EN
    do_reset();
    for (int k = 0; k < 3; k++) begin
      drv(1'b1, 1'b1, 1'b0, 3'b000, 1'b1, 1'b0, 1'b1, 32'h40);
      if_pc = 32'h40;
      #1; chk($sformatf("bht_pre%0d", k), if_pred_taken, (k == 0) ? 0 : 1);
      step();
    end
    idle(); if_pc = 32'h40; #1; chk("bht_sat", if_pred_taken, 1); step();
    idle(); if_pc = 32'h44; #1; chk("bht_other", if_pred_taken, 0); step();
`else
    drv(1'b1, 1'b1, 1'b0, 3'b000, 1'b1, 1'b0, 1'b1, 32'h40);
    if_pc = 32'h40;
    #1; chk("static_mispred", redirect, 1); step();
    idle(); if_pc = 32'h40; #1; chk("static_if_pred", if_pred_taken, 0); step();
    idle(); step();
`endif

    // Randomised run against the model
    for (int n = 0; n < 3000; n++) begin
      int unsigned r;
      @(negedge clk);
      r             = $urandom_range(9);
      ex_valid      = ($urandom_range(3) != 0);
      ex_is_branch  = (r < 7);
      ex_is_jump    = (r >= 8);
      ex_funct3     = 3'($urandom);
      breq          = 1'($urandom);
      brlt          = 1'($urandom);
      ex_pred_taken = 1'($urandom);
      ex_pc         = ($urandom & 32'h3C) | ($urandom_range(1) << 12);
      if_pc         = ($urandom & 32'h3C);
      cnt_clr       = ($urandom_range(40) == 0);
      rst           = ($urandom_range(150) == 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
